ifetch_ctrl: RTL and testbench
==============================

IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, is the number of instruction-queue entries (power of two, at least 2).
REQ-002 Parameter MAX_OUT, default 2, is the maximum number of outstanding imem requests (at most DEPTH).
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 pc_i  in  32  current PC from the pc block.
REQ-006 br_ctrl  in  1  branch redirect; the pc block loads the branch target at this edge.
REQ-007 pc_stall  out  1  holds the PC; driven to the pc block's stall input.
REQ-008 imem_req_valid / imem_req_ready / imem_req_addr  out / in / out  1 / 1 / 32  instruction-memory request handshake.
REQ-009 imem_rsp_valid / imem_rsp_data  in / in  1 / 32  in-order response; no backpressure.
REQ-010 id_valid / id_ready / id_inst / id_pc  out / in / out / out  1 / 1 / 32 / 32  decode-side handshake.
REQ-011 protocol_err  out  1  sticky flag for an unexpected response.

Function
REQ-012 Track outstanding requests as out_cnt (0..MAX_OUT), queue occupancy as occ (0..DEPTH), and responses still to be discarded as drop_cnt (0..MAX_OUT).
REQ-013 Drive imem_req_valid = rst & !br_ctrl & (out_cnt < MAX_OUT) & (out_cnt + occ < DEPTH), combinationally.
REQ-014 Drive imem_req_addr = pc_i, combinationally.
REQ-015 Drive pc_stall = !(imem_req_valid & imem_req_ready), so the PC advances exactly once per accepted request.
REQ-016 On an accepted request, push pc_i into a pending-PC FIFO (MAX_OUT deep) and increment out_cnt.
REQ-017 On imem_rsp_valid with drop_cnt > 0, discard the response and decrement drop_cnt.
REQ-018 On imem_rsp_valid with drop_cnt = 0 and out_cnt > 0, pop the pending-PC FIFO and push {pc, inst} into the queue; the entry is visible at id_valid the next cycle.
REQ-019 Minimum latency: request accepted in cycle N, response in cycle N+1, id_valid in cycle N+2.
REQ-020 On imem_rsp_valid with out_cnt = 0 and drop_cnt = 0, ignore the data and set protocol_err until reset.
REQ-021 Drive id_valid = (occ != 0) & !br_ctrl; id_inst and id_pc come from the queue head.
REQ-022 Pop the queue when id_valid & id_ready.
REQ-023 Push and pop in the same cycle are allowed; occ is then unchanged.
REQ-024 The credit rule in REQ-013 guarantees the queue never overflows.
REQ-025 On br_ctrl, in one edge:
 - empty the queue and clear the pending-PC FIFO;
 - set drop_cnt = drop_cnt + out_cnt - (1 if imem_rsp_valid in this cycle);
 - set out_cnt = 0;
 - discard any response arriving in this cycle and any pop.
REQ-026 br_ctrl on consecutive cycles keeps accumulating drop_cnt, which never exceeds MAX_OUT.
REQ-027 A request issued while drop_cnt > 0 is allowed; its response is kept after the drops drain.
REQ-028 Counter arithmetic is unsigned at $clog2(DEPTH+1) bits; wrap-around is impossible by construction.

Reset
REQ-029 While rst = 0 (asynchronous assertion): out_cnt, occ, drop_cnt, all FIFO pointers and protocol_err are 0; id_valid = 0; imem_req_valid = 0; pc_stall = 1.
REQ-030 Reset asserted mid-operation abandons all in-flight requests; responses arriving after reset release are treated per REQ-020.

Structure
REQ-031 Package ifetch_pkg holds DEPTH/MAX_OUT defaults, the XLEN = 32 constant and the queue-entry typedef {pc, inst}.
REQ-032 One sub-module, ifq_fifo (parameterised width/depth synchronous FIFO with flush), is instantiated twice: once for the pending-PC FIFO and once for the instruction queue.

Verification
REQ-033 Reset release with imem_req_ready = 1 and a 1-cycle memory latency -> requests issued for PC 0x0, 0x4, 0x8...; id_pc sequence 0x0, 0x4 from cycle 2 onward.
REQ-034 id_ready = 0 held -> exactly 4 requests accepted, then pc_stall = 1 and imem_req_valid = 0; one id pop -> exactly one new request.
REQ-035 br_ctrl while 2 requests are outstanding and no response that cycle -> drop_cnt = 2; the next two responses are discarded; the first id_pc equals the branch target, e.g. 0x100.
REQ-036 br_ctrl coinciding with imem_rsp_valid and out_cnt = 2 -> drop_cnt = 1; id_valid = 0 in the br cycle and the cycle after.
REQ-037 imem_rsp_valid with nothing outstanding -> protocol_err = 1 and occ unchanged; protocol_err clears only on rst.
REQ-038 rst asserted asynchronously mid-stream -> all outputs take their REQ-029 values before the next clock edge.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared constants and the instruction-queue entry layout for the fetch controller.
package ifetch_pkg;

  localparam int XLEN        = 32;
  localparam int DEPTH_DEF   = 4;
  localparam int MAX_OUT_DEF = 2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO with single-cycle flush; the caller tracks occupancy and never
// pushes when full or pops when empty.
module ifq_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Explicit wrap so non-power-of-two depths still work.
  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: credit-limited imem requests, in-order response
// capture into a small queue, and branch flush with late-response discard.
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int MAX_OUT = MAX_OUT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_i,
  input  logic            br_ctrl,
  output logic            pc_stall,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_inst,
  output logic [XLEN-1:0] id_pc,
  output logic            protocol_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUT);
  localparam logic [CW:0]   DEPTH_W   = (CW+1)'(DEPTH);

  logic [CW-1:0] out_cnt;
  logic [CW-1:0] occ;
  logic [CW-1:0] drop_cnt;

  logic [CW:0]     credit_sum;
  logic            req_fire;
  logic            rsp_drop;
  logic            rsp_keep;
  logic            rsp_bad;
  logic            br_rsp_dec;
  logic            q_push;
  logic            q_pop;
  logic [XLEN-1:0] pend_pc;
  ifq_entry_t      q_din;
  ifq_entry_t      q_dout;

  // Outstanding requests reserve queue slots, so the queue can never overflow.
  assign credit_sum     = {1'b0, out_cnt} + {1'b0, occ};
  assign imem_req_valid = rst & ~br_ctrl & (out_cnt < MAX_OUT_C) & (credit_sum < DEPTH_W);
  assign imem_req_addr  = pc_i;
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign pc_stall       = ~req_fire;

  assign rsp_drop   = imem_rsp_valid & (drop_cnt != '0);
  assign rsp_keep   = imem_rsp_valid & (drop_cnt == '0) & (out_cnt != '0);
  assign rsp_bad    = imem_rsp_valid & (drop_cnt == '0) & (out_cnt == '0);
  assign br_rsp_dec = imem_rsp_valid & ((drop_cnt != '0) | (out_cnt != '0));

  assign id_valid = (occ != '0) & ~br_ctrl;
  assign q_push   = rsp_keep & ~br_ctrl;
  assign q_pop    = id_valid & id_ready;

  assign q_din.pc   = pend_pc;
  assign q_din.inst = imem_rsp_data;
  assign id_pc      = q_dout.pc;
  assign id_inst    = q_dout.inst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_cnt      <= '0;
      occ          <= '0;
      drop_cnt     <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (rsp_bad) protocol_err <= 1'b1;
      if (br_ctrl) begin
        // Every still-outstanding response becomes one to discard, minus the
        // one landing in this very cycle.
        out_cnt  <= '0;
        occ      <= '0;
        drop_cnt <= drop_cnt + out_cnt - CW'(br_rsp_dec);
      end else begin
        out_cnt  <= out_cnt + CW'(req_fire) - CW'(rsp_keep);
        occ      <= occ + CW'(q_push) - CW'(q_pop);
        drop_cnt <= drop_cnt - CW'(rsp_drop);
      end
    end
  end

  ifq_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUT)) u_pend (
    .clk  (clk),
    .rst  (rst),
    .flush(br_ctrl),
    .push (req_fire),
    .din  (pc_i),
    .pop  (q_push),
    .dout (pend_pc)
  );

  ifq_fifo #(.WIDTH($bits(ifq_entry_t)), .DEPTH(DEPTH)) u_queue (
    .clk  (clk),
    .rst  (rst),
    .flush(br_ctrl),
    .push (q_push),
    .din  (q_din),
    .pop  (q_pop),
    .dout (q_dout)
  );

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: PC/memory models, an expected-fetch scoreboard, a flag
// vector table for backpressure, and hand sequences for branch/error/reset cases.
module tb_ifetch_ctrl;
  import ifetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_i = '0;
  logic        br_ctrl = 1'b0;
  logic        pc_stall;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        protocol_err;

  ifetch_ctrl #(.DEPTH(4), .MAX_OUT(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_i          (pc_i),
    .br_ctrl       (br_ctrl),
    .pc_stall      (pc_stall),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_inst       (id_inst),
    .id_pc         (id_pc),
    .protocol_err  (protocol_err)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] pc_m = '0;
  logic [31:0] mem_q[$];
  ifq_entry_t  exp_q[$];

  typedef struct {
    logic rdy;
    logic exp_rv;
    logic exp_iv;
  } vec_t;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A5A_F00D;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock: drive inputs, sample at negedge, update scoreboard and models.
  task automatic cyc(input logic br, input logic rdy, input logic hold, input logic mrdy,
                     input logic spur, input logic [31:0] tgt,
                     output logic s_rv, output logic s_st, output logic s_iv,
                     output logic s_perr, output logic [31:0] s_pc);
    logic       resp;
    ifq_entry_t e;
    br_ctrl        = br;
    id_ready       = rdy;
    imem_req_ready = mrdy;
    pc_i           = pc_m;
    resp           = 1'b0;
    if (!hold && mem_q.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = inst_of(mem_q[0]);
      resp           = 1'b1;
    end else if (spur) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hBAD0_BAD0;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    @(negedge clk);
    s_rv   = imem_req_valid;
    s_st   = pc_stall;
    s_iv   = id_valid;
    s_perr = protocol_err;
    s_pc   = id_pc;
    if (resp) void'(mem_q.pop_front());
    if (id_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL id_pop_unexpected: got pc %h with no fetch expected", id_pc);
      end else begin
        e = exp_q.pop_front();
        chk("id_pc", id_pc, e.pc);
        chk("id_inst", id_inst, e.inst);
      end
    end
    if (br) exp_q.delete();
    if (imem_req_valid && imem_req_ready) begin
      chk("req_addr", imem_req_addr, pc_m);
      mem_q.push_back(pc_m);
      e.pc   = pc_m;
      e.inst = inst_of(pc_m);
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (br) pc_m = tgt;
    else if (!s_st) pc_m = pc_m + 32'd4;
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b0;
    br_ctrl        = 1'b0;
    id_ready       = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    pc_m           = '0;
    pc_i           = '0;
    mem_q.delete();
    exp_q.delete();
    @(posedge clk);
    #2;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_pc_stall", 32'(pc_stall), 32'd1);
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_protocol_err", 32'(protocol_err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic        rv, st, iv, pe;
    logic [31:0] pc;
    vec_t        tbl[10];
    logic        rdy_seq[10] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    logic        rv_seq[10]  = '{1, 1, 1, 1, 0, 0, 0, 1, 0, 0};
    logic        iv_seq[10]  = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
    for (int i = 0; i < 10; i++) begin
      tbl[i].rdy    = rdy_seq[i];
      tbl[i].exp_rv = rv_seq[i];
      tbl[i].exp_iv = iv_seq[i];
    end

    // Streaming with 1-cycle memory: request every cycle, decode valid from cycle 2.
    do_reset();
    for (int k = 0; k < 12; k++) begin
      cyc(0, 1, 0, 1, 0, 0, rv, st, iv, pe, pc);
      chk("stream_req_valid", 32'(rv), 32'd1);
      chk("stream_id_valid", 32'(iv), (k >= 2) ? 32'd1 : 32'd0);
    end

    // Decode backpressure: four fetches fill the credits, one pop frees one.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(0, tbl[i].rdy, 0, 1, 0, 0, rv, st, iv, pe, pc);
      chk("bp_req_valid", 32'(rv), 32'(tbl[i].exp_rv));
      chk("bp_pc_stall", 32'(st), 32'(!tbl[i].exp_rv));
      chk("bp_id_valid", 32'(iv), 32'(tbl[i].exp_iv));
    end

    // Random decode/imem readiness and branches.
    for (int k = 0; k < 150; k++) begin
      logic br_r;
      br_r = ($urandom_range(0, 11) == 0);
      cyc(br_r, 1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 3) != 0), 0,
          32'h1000 + (32'($urandom_range(0, 1023)) << 2), rv, st, iv, pe, pc);
    end
    for (int i = 0; i < 40 && (exp_q.size() > 0 || mem_q.size() > 0); i++)
      cyc(0, 1, 0, 0, 0, 0, rv, st, iv, pe, pc);
    chk("drain_exp_left", 32'(exp_q.size()), 32'd0);
    chk("random_protocol_err", 32'(protocol_err), 32'd0);

    // Branch with two outstanding, no response that cycle: both late responses dropped.
    do_reset();
    cyc(0, 1, 1, 1, 0, 0, rv, st, iv, pe, pc);
    chk("b2_req0", 32'(rv), 32'd1);
    cyc(0, 1, 1, 1, 0, 0, rv, st, iv, pe, pc);
    chk("b2_req1", 32'(rv), 32'd1);
    cyc(1, 1, 1, 1, 0, 32'h100, rv, st, iv, pe, pc);
    chk("b2_br_req_valid", 32'(rv), 32'd0);
    chk("b2_br_id_valid", 32'(iv), 32'd0);
    cyc(0, 1, 0, 1, 0, 0, rv, st, iv, pe, pc);
    chk("b2_drop0_id_valid", 32'(iv), 32'd0);
    chk("b2_req_during_drop", 32'(rv), 32'd1);
    cyc(0, 1, 0, 1, 0, 0, rv, st, iv, pe, pc);
    chk("b2_drop1_id_valid", 32'(iv), 32'd0);
    cyc(0, 1, 0, 1, 0, 0, rv, st, iv, pe, pc);
    chk("b2_keep_id_valid", 32'(iv), 32'd0);
    chk("b2_credit_full", 32'(rv), 32'd0);
    cyc(0, 1, 0, 1, 0, 0, rv, st, iv, pe, pc);
    chk("b2_first_id_valid", 32'(iv), 32'd1);
    chk("b2_first_id_pc", pc, 32'h100);

    // Branch coinciding with a response while two are outstanding: one drop.
    do_reset();
    cyc(0, 1, 1, 1, 0, 0, rv, st, iv, pe, pc);
    cyc(0, 1, 1, 1, 0, 0, rv, st, iv, pe, pc);
    cyc(1, 1, 0, 1, 0, 32'h200, rv, st, iv, pe, pc);
    chk("b1_br_id_valid", 32'(iv), 32'd0);
    cyc(0, 1, 0, 1, 0, 0, rv, st, iv, pe, pc);
    chk("b1_after_id_valid", 32'(iv), 32'd0);
    cyc(0, 1, 0, 1, 0, 0, rv, st, iv, pe, pc);
    chk("b1_keep_id_valid", 32'(iv), 32'd0);
    cyc(0, 1, 0, 1, 0, 0, rv, st, iv, pe, pc);
    chk("b1_first_id_valid", 32'(iv), 32'd1);
    chk("b1_first_id_pc", pc, 32'h200);

    // Spurious response: sticky error, queue untouched; only reset clears it.
    do_reset();
    cyc(0, 0, 0, 0, 1, 0, rv, st, iv, pe, pc);
    chk("perr_before", 32'(pe), 32'd0);
    cyc(0, 0, 0, 0, 0, 0, rv, st, iv, pe, pc);
    chk("perr_set", 32'(pe), 32'd1);
    chk("perr_occ_unchanged", 32'(iv), 32'd0);
    for (int k = 0; k < 6; k++) cyc(0, 1, 0, 1, 0, 0, rv, st, iv, pe, pc);
    chk("perr_sticky", 32'(pe), 32'd1);
    chk("pre_rst_id_valid", 32'(iv), 32'd1);

    // Asynchronous reset mid-stream: outputs settle before the next edge.
    #1;
    rst = 1'b0;
    #1;
    chk("async_req_valid", 32'(imem_req_valid), 32'd0);
    chk("async_pc_stall", 32'(pc_stall), 32'd1);
    chk("async_id_valid", 32'(id_valid), 32'd0);
    chk("async_protocol_err", 32'(protocol_err), 32'd0);
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
